// File: rtl/output_gain_pkg.sv
// -----------------------------------------------------------------------------
// output_gain_pkg
//   Shared types and constants for the output gain stage.
//   - ramp_state_e : gain-ramp FSM states (RUN, FADE_OUT, MUTED, FADE_IN)
//   - GAIN_W       : width of a gain code (0..31, effective gain = code/16)
//   - GAIN_UNITY   : gain code for unity gain
//   - PROD_W       : width of the signed sample x gain product
//   - SAMPLE_MAX / SAMPLE_MIN : saturation limits of a 16-bit signed sample
// -----------------------------------------------------------------------------
package output_gain_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 5;
  localparam int GAIN_UNITY = 16;
  localparam int PROD_W     = 22;
  localparam int FRAC_BITS  = 4;   // gain code is Q1.4: code/16

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FADE_OUT = 2'd1,
    MUTED    = 2'd2,
    FADE_IN  = 2'd3
  } ramp_state_e;

endpackage

// File: rtl/gain_ramp.sv
// -----------------------------------------------------------------------------
// gain_ramp
//   Owns the applied gain code. In RUN the gain walks one code toward the
//   requested target every STEP_SAMPLES input samples; a mute toggle fades the
//   gain down to zero (one code per sample), and a second toggle fades it back
//   up to the live target before returning to RUN.
//
//   Parameters
//     STEP_SAMPLES : input samples per gain step in RUN (1..1024)
//     RESET_GAIN   : gain code loaded at reset
//   Ports
//     clk          : clock, rising edge
//     reset        : synchronous, active-high
//     in_ready     : one-cycle sample strobe (one ramp tick per strobe)
//     target_gain  : requested gain code
//     mute_toggle  : one-cycle mute/unmute request
//     gain_now     : gain code currently applied
//     muted        : high only in MUTED
// -----------------------------------------------------------------------------
module gain_ramp
  import output_gain_pkg::*;
#(
  parameter int STEP_SAMPLES = 64,
  parameter int RESET_GAIN   = GAIN_UNITY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_ready,
  input  logic [GAIN_W-1:0] target_gain,
  input  logic              mute_toggle,
  output logic [GAIN_W-1:0] gain_now,
  output logic              muted
);

  localparam int CNT_W = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1);
  localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(RESET_GAIN);

  ramp_state_e       state, state_next, eff_state;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [GAIN_W-1:0] gain, gain_next;
  logic [GAIN_W-1:0] toward;

  // One code toward the live target, or unchanged when already there.
  always_comb begin
    if (gain < target_gain)      toward = gain + GAIN_ONE;
    else if (gain > target_gain) toward = gain - GAIN_ONE;
    else                         toward = gain;
  end

  // A toggle takes effect in the same cycle: the gain step of a coincident
  // sample strobe is governed by the state the toggle leads to.
  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    eff_state  = state;
    state_next = state;
    gain_next  = gain;
    cnt_next   = cnt;

    if (mute_toggle) begin
      case (state)
        RUN:      eff_state = FADE_OUT;
        FADE_OUT: eff_state = FADE_IN;
        MUTED:    eff_state = FADE_IN;
        FADE_IN:  eff_state = FADE_OUT;
        default:  eff_state = state;
      endcase
    end
    state_next = eff_state;

    case (eff_state)
      RUN: begin
        if (in_ready) begin
          if (cnt == CNT_LAST) begin
            cnt_next  = '0;
            gain_next = toward;
          end else begin
            cnt_next  = cnt + CNT_ONE;
          end
        end
      end
      FADE_OUT: begin
        if (in_ready && (gain != '0)) gain_next = gain - GAIN_ONE;
        // Leaves as soon as zero is reached, or at once if already zero.
        if (gain_next == '0) state_next = MUTED;
      end
      MUTED: begin
        gain_next = '0;
      end
      FADE_IN: begin
        if (in_ready) gain_next = toward;
        if (gain_next == target_gain) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      gain  <= GAIN_RST;
      cnt   <= '0;
    end else begin
      state <= state_next;
      gain  <= gain_next;
      cnt   <= cnt_next;
    end
  end

  assign gain_now = gain;
  assign muted    = (state == MUTED);

endmodule

// File: rtl/output_gain_stage.sv
// -----------------------------------------------------------------------------
// output_gain_stage
//   Two-stage pipelined volume stage between the echo stage and the codec.
//   Stage 1 registers sample x gain (22-bit signed); stage 2 scales by 1/16
//   (arithmetic shift, floor) and saturates to 16 bits. Latency is fixed at two
//   cycles from in_ready to out_ready; a new sample may arrive every cycle.
//   Gain ramping and mute fading live in gain_ramp.
//
//   Build option
//     OUTPUT_GAIN_CLIP_CNT_EN : when defined, clip_count counts saturated
//                               output samples (sticks at 0xFFFF); otherwise
//                               clip_count is tied to zero.
//
//   Parameters
//     STEP_SAMPLES : input samples per gain step in RUN (1..1024)
//     RESET_GAIN   : gain code loaded at reset (16 = unity)
//   Ports
//     clk          : clock, rising edge
//     reset        : synchronous, active-high; drops in-flight samples
//     sample_in    : signed PCM sample, valid with in_ready
//     in_ready     : one-cycle input strobe
//     target_gain  : requested gain code 0..31 (rotary encoder)
//     mute_toggle  : one-cycle mute/unmute pulse
//     out          : signed gained sample, held between strobes
//     out_ready    : one-cycle output strobe
//     gain_now     : gain code currently applied
//     muted        : high only while fully muted
//     clip_count   : number of saturated output samples
// -----------------------------------------------------------------------------
module output_gain_stage
  import output_gain_pkg::*;
#(
  parameter int STEP_SAMPLES = 64,
  parameter int RESET_GAIN   = GAIN_UNITY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       in_ready,
  input  logic        [GAIN_W-1:0]   target_gain,
  input  logic                       mute_toggle,
  output logic signed [SAMPLE_W-1:0] out,
  output logic                       out_ready,
  output logic        [GAIN_W-1:0]   gain_now,
  output logic                       muted,
  output logic        [15:0]         clip_count
);

  localparam logic signed [PROD_W-1:0] PROD_MAX = PROD_W'(SAMPLE_MAX);
  localparam logic signed [PROD_W-1:0] PROD_MIN = PROD_W'(SAMPLE_MIN);

  gain_ramp #(
    .STEP_SAMPLES (STEP_SAMPLES),
    .RESET_GAIN   (RESET_GAIN)
  ) u_gain_ramp (
    .clk         (clk),
    .reset       (reset),
    .in_ready    (in_ready),
    .target_gain (target_gain),
    .mute_toggle (mute_toggle),
    .gain_now    (gain_now),
    .muted       (muted)
  );

  logic                       valid1;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   shifted;
  logic signed [SAMPLE_W-1:0] sat_val;

  // Stage 1: valid bit is reset so a reset drops whatever is in flight.
  always_ff @(posedge clk) begin
    if (reset) valid1 <= 1'b0;
    else       valid1 <= in_ready;
  end

  // NOTE: the product register carries no reset; it is only ever consumed
  // qualified by valid1, which is reset.
  always_ff @(posedge clk) begin
    if (in_ready)
      prod <= PROD_W'(sample_in) * PROD_W'($signed({1'b0, gain_now}));
  end

  // Stage 2: divide by 16 rounding toward minus infinity, then clamp.
  assign shifted = prod >>> FRAC_BITS;

  always_comb begin
    if (shifted > PROD_MAX)      sat_val = SAMPLE_MAX;
    else if (shifted < PROD_MIN) sat_val = SAMPLE_MIN;
    else                         sat_val = shifted[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_ready <= 1'b0;
    end else begin
      out_ready <= valid1;
      if (valid1) out <= sat_val;
    end
  end

`ifdef OUTPUT_GAIN_CLIP_CNT_EN
  logic        sat_hit;
  logic [15:0] clip_q;

  assign sat_hit = (shifted > PROD_MAX) || (shifted < PROD_MIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      clip_q <= '0;
    end else if (valid1 && sat_hit && (clip_q != 16'hFFFF)) begin
      clip_q <= clip_q + 16'd1;
    end
  end

  assign clip_count = clip_q;
`else
  assign clip_count = '0;
`endif

endmodule
